// File: rtl/axis_contrast_stretch.sv
// AXI-Stream contrast stretch: out = clamp(((pix - lo) sat 0) * gain >> 8).
// Two-stage pipeline (S1 subtract/multiply, S2 shift/clamp) with per-frame
// shadowed configuration and per-frame min/max statistics on the input pixels.
module axis_contrast_stretch #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    input  logic             s_tuser,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             s_tready,
    output logic             m_tvalid,
    output logic             m_tlast,
    output logic             m_tuser,
    output logic [WIDTH-1:0] m_tdata,
    input  logic             m_tready,
    input  logic [WIDTH-1:0] cfg_lo,
    input  logic [15:0]      cfg_gain,
    input  logic             cfg_bypass,
    output logic [WIDTH-1:0] stat_min,
    output logic [WIDTH-1:0] stat_max,
    output logic             stat_valid,
    output logic             frame_err
);

    localparam int PW = WIDTH + 16;
    localparam int CW = $clog2(HEIGHT + 1);
    localparam logic [CW-1:0] LAST_LINE = CW'(HEIGHT);

    // Pipeline state
    logic             v1_reg, last1_reg, user1_reg, byp1_reg;
    logic [WIDTH-1:0] raw1_reg;
    logic [PW-1:0]    prod1_reg;
    logic             v2_reg, last2_reg, user2_reg;
    logic [WIDTH-1:0] data2_reg;

    // Shadow configuration
    logic [WIDTH-1:0] lo_act_reg;
    logic [15:0]      gain_act_reg;
    logic             bypass_act_reg;

    // Statistics state
    logic [CW-1:0]    cnt_reg;
    logic             active_reg;
    logic [WIDTH-1:0] run_min_reg, run_max_reg;
    logic [WIDTH-1:0] stat_min_reg, stat_max_reg;
    logic             stat_valid_reg, frame_err_reg;

    logic             advance, acc, sof_acc;
    logic [WIDTH-1:0] lo_eff;
    logic [15:0]      gain_eff;
    logic             bypass_eff;
    logic [WIDTH-1:0] diff;
    logic [PW-1:0]    prod;
    logic [PW-9:0]    shifted;
    logic [WIDTH-1:0] clamped, pix2;
    logic             in_stats, frame_done;
    logic [CW-1:0]    cnt_after;
    logic [WIDTH-1:0] new_min, new_max;
    logic             unused_low;

    // The whole pipe moves when the output register is free or being drained.
    assign advance = !v2_reg || m_tready;
    assign s_tready = advance;
    assign acc     = s_tvalid && advance;
    assign sof_acc = acc && s_tuser;

    assign m_tvalid   = v2_reg;
    assign m_tlast    = last2_reg;
    assign m_tuser    = user2_reg;
    assign m_tdata    = data2_reg;
    assign stat_min   = stat_min_reg;
    assign stat_max   = stat_max_reg;
    assign stat_valid = stat_valid_reg;
    assign frame_err  = frame_err_reg;

    // S1 arithmetic: the SOF beat already uses the new configuration.
    always_comb begin
        lo_eff     = lo_act_reg;
        gain_eff   = gain_act_reg;
        bypass_eff = bypass_act_reg;
        if (sof_acc) begin
            lo_eff     = cfg_lo;
            gain_eff   = cfg_gain;
            bypass_eff = cfg_bypass;
        end
        diff = (s_tdata > lo_eff) ? (s_tdata - lo_eff) : '0;
        prod = {16'd0, diff} * {{WIDTH{1'b0}}, gain_eff};
    end

    // S2 arithmetic: drop the Q8.8 fraction and saturate to full scale.
    always_comb begin
        shifted = prod1_reg[PW-1:8];
        clamped = (|shifted[PW-9:WIDTH]) ? '1 : shifted[WIDTH-1:0];
        pix2    = byp1_reg ? raw1_reg : clamped;
    end

    // Fraction bits are discarded by design.
    assign unused_low = ^prod1_reg[7:0];

    // Pipeline registers: both stages advance together, tlast/tuser ride along.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg    <= 1'b0;
            last1_reg <= 1'b0;
            user1_reg <= 1'b0;
            byp1_reg  <= 1'b0;
            raw1_reg  <= '0;
            prod1_reg <= '0;
            v2_reg    <= 1'b0;
            last2_reg <= 1'b0;
            user2_reg <= 1'b0;
            data2_reg <= '0;
        end else if (advance) begin
            v1_reg    <= s_tvalid;
            last1_reg <= s_tlast;
            user1_reg <= s_tuser;
            byp1_reg  <= bypass_eff;
            raw1_reg  <= s_tdata;
            prod1_reg <= prod;
            v2_reg    <= v1_reg;
            last2_reg <= last1_reg;
            user2_reg <= user1_reg;
            data2_reg <= pix2;
        end
    end

    // Shadow configuration latches on every accepted SOF beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_act_reg     <= '0;
            gain_act_reg   <= 16'h0100;
            bypass_act_reg <= 1'b0;
        end else if (sof_acc) begin
            lo_act_reg     <= cfg_lo;
            gain_act_reg   <= cfg_gain;
            bypass_act_reg <= cfg_bypass;
        end
    end

    // Running min/max and line count for the beat being accepted this cycle.
    always_comb begin
        in_stats = acc && (s_tuser || active_reg);
        if (s_tuser) begin
            cnt_after = s_tlast ? CW'(1) : '0;
            new_min   = s_tdata;
            new_max   = s_tdata;
        end else begin
            cnt_after = cnt_reg + CW'(s_tlast);
            new_min   = (s_tdata < run_min_reg) ? s_tdata : run_min_reg;
            new_max   = (s_tdata > run_max_reg) ? s_tdata : run_max_reg;
        end
        frame_done = in_stats && s_tlast && (cnt_after == LAST_LINE);
    end

    // Statistics registers; active_reg marks an open, not yet complete frame,
    // so beats outside a frame are ignored and the counter holds at HEIGHT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            active_reg     <= 1'b0;
            run_min_reg    <= '0;
            run_max_reg    <= '0;
            stat_min_reg   <= '0;
            stat_max_reg   <= '0;
            stat_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            stat_valid_reg <= frame_done;
            frame_err_reg  <= sof_acc && active_reg;
            if (in_stats) begin
                cnt_reg     <= cnt_after;
                run_min_reg <= new_min;
                run_max_reg <= new_max;
                active_reg  <= !frame_done;
            end
            if (frame_done) begin
                stat_min_reg <= new_min;
                stat_max_reg <= new_max;
            end
        end
    end

endmodule
